// File: rtl/mem_initiator.sv
// Memory-side strobe master: sequences N_OE/N_WE with setup, strobe-width and recovery
// cycles, and does read-modify-write for sub-word stores. Optional: MEM_INITIATOR_ALIGN_CHECK_EN.
module mem_initiator #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        REQ,
    input  logic        WR,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic [31:0] ADDR,
    output logic        N_WE,
    output logic        N_OE,
    output logic [31:0] BUS_OUT,
    input  logic [31:0] BUS_IN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_SETUP,
        S_WR,
        S_FIN
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 32'd1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_lo;
    logic [15:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_rdata;
    logic [31:0] r_addr;
    logic        r_n_we;
    logic        r_n_oe;
    logic [31:0] r_bus_out;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merge;

    // Lane extraction and sub-word merge both work on the word currently on BUS_IN.
    always_comb begin
        w_byte = BUS_IN[{r_lo, 3'b000} +: 8];
        w_half = r_lo[1] ? BUS_IN[31:16] : BUS_IN[15:0];
        case (r_size)
            2'b00:   w_load_val = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_val = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_val = BUS_IN;
        endcase
    end

    always_comb begin
        w_merge = BUS_IN;
        if (r_size == 2'b00) begin
            w_merge[{r_lo, 3'b000} +: 8] = r_data[7:0];
        end else if (r_lo[1]) begin
            w_merge[31:16] = r_data;
        end else begin
            w_merge[15:0] = r_data;
        end
    end

`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
    logic r_err;
    logic w_misalign;

    assign w_misalign = ((SIZE == 2'b01) && REQ_ADDR[0]) ||
                        (SIZE[1] && (REQ_ADDR[1:0] != 2'b00));
    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wr      <= 1'b0;
            r_size    <= '0;
            r_signed  <= 1'b0;
            r_lo      <= '0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_n_we    <= 1'b1;
            r_n_oe    <= 1'b1;
            r_bus_out <= '0;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        r_wr     <= WR;
                        r_size   <= SIZE;
                        r_signed <= SIGNED;
                        r_lo     <= REQ_ADDR[1:0];
                        r_data   <= REQ_DATA[15:0];
                        r_addr   <= {REQ_ADDR[31:2], 2'b00};
                        r_busy   <= 1'b1;
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
                        r_err    <= w_misalign;
                        if (w_misalign) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else
`endif
                        if (WR && SIZE[1]) begin
                            r_bus_out <= REQ_DATA;
                            r_state   <= S_SETUP;
                        end else begin
                            r_n_oe  <= 1'b0;
                            r_cnt   <= CNT_INIT;
                            r_state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == 4'd0) begin
                        r_n_oe <= 1'b1;
                        if (r_wr) begin
                            r_bus_out <= w_merge;
                            r_state   <= S_SETUP;
                        end else begin
                            r_rdata <= w_load_val;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SETUP: begin
                    r_n_we  <= 1'b0;
                    r_cnt   <= CNT_INIT;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (r_cnt == 4'd0) begin
                        r_n_we  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign RDATA   = r_rdata;
    assign ADDR    = r_addr;
    assign N_WE    = r_n_we;
    assign N_OE    = r_n_oe;
    assign BUS_OUT = r_bus_out;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: three instances (WAIT_CYCLES 1, 2, 4), each with its own
// word memory model, plus a per-cycle strobe invariant monitor.
module tb_mem_initiator;

    localparam int unsigned NI = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        wr, sgn;
    logic [1:0]  size;
    logic [31:0] req_addr, req_data;
    logic        req   [NI];
    logic        rst_n [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic        err   [NI];
    logic [31:0] rdata [NI];
    logic [31:0] addr  [NI];
    logic        n_we  [NI];
    logic        n_oe  [NI];
    logic [31:0] bus_out [NI];
    logic [31:0] bus_in  [NI];
    logic [31:0] peek    [NI];

    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [31:0] mem [256];

        mem_initiator #(.WAIT_CYCLES(WC)) u_dut (
            .CLK(CLK), .N_RST(rst_n[g]), .REQ(req[g]), .WR(wr), .SIZE(size),
            .SIGNED(sgn), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
            .BUSY(busy[g]), .DONE(done[g]), .ERR(err[g]), .RDATA(rdata[g]),
            .ADDR(addr[g]), .N_WE(n_we[g]), .N_OE(n_oe[g]),
            .BUS_OUT(bus_out[g]), .BUS_IN(bus_in[g])
        );

        assign bus_in[g] = mem[addr[g][9:2]];
        assign peek[g]   = mem[pl_idx];

        always @(posedge CLK) begin
            if (pl_en) mem[pl_idx] <= pl_data;
            else if (!n_we[g]) mem[addr[g][9:2]] <= bus_out[g];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Strobe invariants on every instance out of reset
    logic        p_we  [NI];
    logic        p_oe  [NI];
    logic [31:0] p_addr[NI];
    logic [31:0] p_bus [NI];
    always @(negedge CLK) begin
        for (int k = 0; k < int'(NI); k++) begin
            if (rst_n[k] === 1'b1) begin
                check_val("strobe_excl", {31'b0, n_we[k] | n_oe[k]}, 32'd1);
                if (((!n_oe[k] && !p_oe[k]) || (!n_we[k] && !p_we[k])) || (!n_we[k] && p_we[k])) begin
                    check_val("addr_stable", addr[k], p_addr[k]);
                    check_val("bus_stable", bus_out[k], p_bus[k]);
                end
            end
            p_we[k]   = n_we[k];
            p_oe[k]   = n_oe[k];
            p_addr[k] = addr[k];
            p_bus[k]  = bus_out[k];
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        pl_en = 1'b1; pl_idx = a[9:2]; pl_data = d;
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task automatic peek_mem(input int k, input logic [31:0] a, output logic [31:0] v);
        pl_idx = a[9:2];
        #1;
        v = peek[k];
    endtask

    // Issue one request; cycle 0 is the cycle in which REQ is first high.
    task automatic do_req(input int k, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d, output int dcyc,
                          output logic [31:0] oem, output logic [31:0] wem,
                          output logic e, output logic [31:0] rd);
        oem = '0; wem = '0; dcyc = -1; e = 1'b0; rd = '0;
        @(negedge CLK);
        wr = w; size = sz; sgn = sg; req_addr = a; req_data = d; req[k] = 1'b1;
        for (int c = 1; c < 32; c++) begin
            @(negedge CLK);
            req[k] = 1'b0;
            if (!n_oe[k]) oem[c] = 1'b1;
            if (!n_we[k]) wem[c] = 1'b1;
            if (done[k]) begin
                dcyc = c; e = err[k]; rd = rdata[k];
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc, fd, sd;
        logic [31:0] om, wm, rd, mv;
        logic        e, b_acc, b_aft, seen;

        wr = 0; sgn = 0; size = 0; req_addr = 0; req_data = 0;
        pl_en = 0; pl_idx = 0; pl_data = 0;
        for (int k = 0; k < int'(NI); k++) begin req[k] = 0; rst_n[k] = 0; end
        repeat (2) @(negedge CLK);

        check_val("rst_addr", addr[0], 32'h0);
        check_val("rst_bus_out", bus_out[0], 32'h0);
        check_val("rst_rdata", rdata[0], 32'h0);
        check_val("rst_done", {31'b0, done[0]}, 32'h0);
        check_val("rst_err", {31'b0, err[0]}, 32'h0);
        for (int k = 0; k < int'(NI); k++) begin
            check_val("rst_busy", {31'b0, busy[k]}, 32'h0);
            check_val("rst_strobes", {30'b0, n_we[k], n_oe[k]}, 32'h3);
        end
        for (int k = 0; k < int'(NI); k++) rst_n[k] = 1'b1;

        preload(32'h100, 32'hDEADBEEF);
        preload(32'h104, 32'h80FF7F01);
        preload(32'h200, 32'h11223344);

        // Word load, W=1
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, dc, om, wm, e, rd);
        check_val("ldw_done_cyc", dc, 32'd2);
        check_val("ldw_oe_cycles", om, 32'h2);
        check_val("ldw_we_cycles", wm, 32'h0);
        check_val("ldw_rdata", rd, 32'hDEADBEEF);
        check_val("ldw_err", {31'b0, e}, 32'h0);

        // Sub-word loads, W=2
        do_req(1, 1'b0, 2'b00, 1'b1, 32'h107, 32'h0, dc, om, wm, e, rd);
        check_val("ldb_s_done_cyc", dc, 32'd3);
        check_val("ldb_s_oe_cycles", om, 32'h6);
        check_val("ldb_s_rdata", rd, 32'hFFFFFF80);
        do_req(1, 1'b0, 2'b00, 1'b0, 32'h107, 32'h0, dc, om, wm, e, rd);
        check_val("ldb_u_rdata", rd, 32'h00000080);
        do_req(1, 1'b0, 2'b00, 1'b1, 32'h105, 32'h0, dc, om, wm, e, rd);
        check_val("ldb_s_pos_rdata", rd, 32'h0000007F);
        do_req(1, 1'b0, 2'b01, 1'b1, 32'h106, 32'h0, dc, om, wm, e, rd);
        check_val("ldh_s_hi_rdata", rd, 32'hFFFF80FF);
        do_req(1, 1'b0, 2'b01, 1'b1, 32'h104, 32'h0, dc, om, wm, e, rd);
        check_val("ldh_s_lo_rdata", rd, 32'h00007F01);

        // Byte store RMW, W=1
        do_req(0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AB, dc, om, wm, e, rd);
        check_val("stb_done_cyc", dc, 32'd4);
        check_val("stb_oe_cycles", om, 32'h2);
        check_val("stb_we_cycles", wm, 32'h8);
        check_val("stb_rdata_held", rd, 32'hDEADBEEF);
        @(negedge CLK);
        peek_mem(0, 32'h200, mv);
        check_val("stb_mem", mv, 32'h1122AB44);

        // Half store RMW, W=2
        do_req(1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h00005566, dc, om, wm, e, rd);
        check_val("sth_done_cyc", dc, 32'd6);
        check_val("sth_oe_cycles", om, 32'h6);
        check_val("sth_we_cycles", wm, 32'h30);
        @(negedge CLK);
        peek_mem(1, 32'h200, mv);
        check_val("sth_mem", mv, 32'h55663344);

        // Back-to-back with REQ held: word store then load, W=1
        fd = -1; sd = -1; b_acc = 1'b1; b_aft = 1'b0; rd = '0;
        @(negedge CLK);
        wr = 1'b1; size = 2'b10; sgn = 1'b0; req_addr = 32'h10; req_data = 32'hCAFEF00D; req[0] = 1'b1;
        for (int c = 1; c < 40; c++) begin
            @(negedge CLK);
            if (fd > 0 && c == fd + 1) b_acc = busy[0];
            if (fd > 0 && c == fd + 2) b_aft = busy[0];
            if (done[0]) begin
                if (fd < 0) begin
                    fd = c; wr = 1'b0;
                end else begin
                    sd = c; rd = rdata[0];
                    break;
                end
            end
        end
        req[0] = 1'b0;
        check_val("b2b_first_done", fd, 32'd3);
        check_val("b2b_second_done", sd, 32'd6);
        check_val("b2b_idle_gap", {31'b0, b_acc}, 32'h0);
        check_val("b2b_busy_after", {31'b0, b_aft}, 32'h1);
        check_val("b2b_rdata", rd, 32'hCAFEF00D);
        peek_mem(0, 32'h10, mv);
        check_val("b2b_mem", mv, 32'hCAFEF00D);

        // Reset in the second WR cycle, W=4
        @(negedge CLK);
        wr = 1'b1; size = 2'b10; req_addr = 32'h300; req_data = 32'h12345678; req[2] = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            req[2] = 1'b0;
        end
        check_val("rstwr_we_low", {31'b0, n_we[2]}, 32'h0);
        rst_n[2] = 1'b0;
        #1;
        check_val("rstwr_we_high", {31'b0, n_we[2]}, 32'h1);
        check_val("rstwr_busy", {31'b0, busy[2]}, 32'h0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            seen = seen | done[2];
        end
        rst_n[2] = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            seen = seen | done[2];
        end
        check_val("rstwr_no_done", {31'b0, seen}, 32'h0);
        do_req(2, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, dc, om, wm, e, rd);
        check_val("rstwr_ld_done_cyc", dc, 32'd5);
        check_val("rstwr_ld_rdata", rd, 32'hDEADBEEF);

        // Misaligned word load, W=1
        do_req(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, dc, om, wm, e, rd);
`ifdef MEM_INITIATOR_ALIGN_CHECK_EN
        check_val("mis_done_cyc", dc, 32'd1);
        check_val("mis_err", {31'b0, e}, 32'h1);
        check_val("mis_oe_cycles", om, 32'h0);
        check_val("mis_we_cycles", wm, 32'h0);
        check_val("mis_rdata_held", rd, 32'hCAFEF00D);
`else
        check_val("mis_done_cyc", dc, 32'd2);
        check_val("mis_err", {31'b0, e}, 32'h0);
        check_val("mis_rdata", rd, 32'hDEADBEEF);
`endif

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
